// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin front end sharing one binary_divider among
// NUM_REQ requesters. Latches a winner's operands, pre-checks divide-by-zero
// and quotient overflow, pulses div_en, waits (bounded) for done and returns
// an 8-bit quotient plus error flag to the winner.
module divider_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [16*NUM_REQ-1:0] req_dividend,
   input  logic [16*NUM_REQ-1:0] req_divisor,
   output logic [NUM_REQ-1:0]    gnt,
   output logic [NUM_REQ-1:0]    resp_valid,
   output logic [7:0]            resp_quotient,
   output logic                  resp_err,
   output logic                  div_en,
   output logic [15:0]           g_dividend_Q,
   output logic [15:0]           g_divider_Q,
   input  logic [7:0]            quotient,
   input  logic                  done
);
   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   typedef enum logic [1:0] {E_NONE, E_DIV0, E_OVF} err_t;

   state_t             state_q, state_d;
   err_t               err_kind_q, err_kind_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [CW-1:0]      wait_cnt_q, wait_cnt_d;
   logic [15:0]        dvd_q, dvd_d, dvs_q, dvs_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d, resp_valid_q, resp_valid_d;
   logic [7:0]         resp_quot_q, resp_quot_d;
   logic               resp_err_q, resp_err_d, div_en_q, div_en_d;

   logic               win_found;
   logic [IW-1:0]      win_idx;
   logic [IW:0]        scan;
   logic [15:0]        win_dvd, win_dvs;
   err_t               win_err;

   // Round-robin scan: first requesting index at or after rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (scan >= (IW+1)'(NUM_REQ)) scan = scan - (IW+1)'(NUM_REQ);
         if (!win_found && req[scan[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan[IW-1:0];
         end
      end
   end

   // Winner operands and the error classification made at latch time.
   // Quotient > 255 exactly when dividend >= divisor*256.
   always_comb begin
      win_dvd = req_dividend[16*int'(win_idx) +: 16];
      win_dvs = req_divisor[16*int'(win_idx) +: 16];
      win_err = E_NONE;
      if (win_dvs == 16'd0)                         win_err = E_DIV0;
      else if ({8'd0, win_dvd} >= {win_dvs, 8'd0}) win_err = E_OVF;
   end

   // Next-state and registered-output computation; pulses default low.
   always_comb begin
      state_d      = state_q;
      err_kind_d   = err_kind_q;
      rr_ptr_d     = rr_ptr_q;
      idx_d        = idx_q;
      wait_cnt_d   = wait_cnt_q;
      dvd_d        = dvd_q;
      dvs_d        = dvs_q;
      gnt_d        = '0;
      resp_valid_d = '0;
      div_en_d     = 1'b0;
      resp_quot_d  = resp_quot_q;
      resp_err_d   = resp_err_q;
      unique case (state_q)
         S_IDLE: begin
            if (win_found) begin
               idx_d          = win_idx;
               dvd_d          = win_dvd;
               dvs_d          = win_dvs;
               err_kind_d     = win_err;
               gnt_d[win_idx] = 1'b1;
               div_en_d       = (win_err == E_NONE);
               state_d        = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (err_kind_q != E_NONE) begin
               resp_valid_d[idx_q] = 1'b1;
               resp_quot_d         = 8'hFF;
               resp_err_d          = 1'b1;
               state_d             = S_RESP;
            end else begin
               wait_cnt_d = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            // done wins over a timeout landing in the same cycle
            if (done) begin
               resp_valid_d[idx_q] = 1'b1;
               resp_quot_d         = quotient;
               resp_err_d          = 1'b0;
               state_d             = S_RESP;
            end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
               resp_valid_d[idx_q] = 1'b1;
               resp_quot_d         = 8'h00;
               resp_err_d          = 1'b1;
               state_d             = S_RESP;
            end
         end
         S_RESP: begin
            rr_ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         err_kind_q   <= E_NONE;
         rr_ptr_q     <= '0;
         idx_q        <= '0;
         wait_cnt_q   <= '0;
         dvd_q        <= '0;
         dvs_q        <= '0;
         gnt_q        <= '0;
         resp_valid_q <= '0;
         div_en_q     <= 1'b0;
         resp_quot_q  <= '0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         err_kind_q   <= err_kind_d;
         rr_ptr_q     <= rr_ptr_d;
         idx_q        <= idx_d;
         wait_cnt_q   <= wait_cnt_d;
         dvd_q        <= dvd_d;
         dvs_q        <= dvs_d;
         gnt_q        <= gnt_d;
         resp_valid_q <= resp_valid_d;
         div_en_q     <= div_en_d;
         resp_quot_q  <= resp_quot_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign gnt           = gnt_q;
   assign resp_valid    = resp_valid_q;
   assign resp_quotient = resp_quot_q;
   assign resp_err      = resp_err_q;
   assign div_en        = div_en_q;
   assign g_dividend_Q  = dvd_q;
   assign g_divider_Q   = dvs_q;

endmodule
